// File: rtl/herculesae_sha256_pkg.sv
`default_nettype none
// ============================================================================
// herculesae_sha256_pkg : shared types and sigma functions for the SHA-256
//                         message-schedule engine
// Rev 1.0
// ============================================================================
package herculesae_sha256_pkg;

  localparam int SHA256_MAX_ROUNDS = 64;

  typedef logic [31:0] sha_word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wsched_state_t;

  function automatic sha_word_t sha256_sigma0(input sha_word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic sha_word_t sha256_sigma1(input sha_word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/herculesae_vx_sha256_wsum.sv
`default_nettype none
// ============================================================================
// herculesae_vx_sha256_wsum : combinational W[t+16] sum,
//                             sigma1(w14) + w9 + sigma0(w1) + w0 mod 2^32
// Rev 1.0
// ============================================================================
module herculesae_vx_sha256_wsum
  import herculesae_sha256_pkg::*;
(
  input  sha_word_t w0_i,
  input  sha_word_t w1_i,
  input  sha_word_t w9_i,
  input  sha_word_t w14_i,
  output sha_word_t sum_o
);

  sha_word_t s0_w;
  sha_word_t s1_w;
  sha_word_t csa_a_sum_w;
  sha_word_t csa_a_cy_w;
  sha_word_t csa_b_sum_w;
  sha_word_t csa_b_cy_w;
  sha_word_t maj_a_w;
  sha_word_t maj_b_w;

  assign s0_w = sha256_sigma0(w1_i);
  assign s1_w = sha256_sigma1(w14_i);

  // Two carry-save layers reduce four operands to two; carries out of bit 31 drop (mod 2^32).
  assign csa_a_sum_w = s1_w ^ w9_i ^ s0_w;
  assign maj_a_w     = (s1_w & w9_i) | (s1_w & s0_w) | (w9_i & s0_w);
  assign csa_a_cy_w  = {maj_a_w[30:0], 1'b0};

  assign csa_b_sum_w = csa_a_sum_w ^ csa_a_cy_w ^ w0_i;
  assign maj_b_w     = (csa_a_sum_w & csa_a_cy_w) | (csa_a_sum_w & w0_i) | (csa_a_cy_w & w0_i);
  assign csa_b_cy_w  = {maj_b_w[30:0], 1'b0};

  assign sum_o = csa_b_sum_w + csa_b_cy_w;

endmodule
`default_nettype wire

// File: rtl/herculesae_vx_sha256_wsched.sv
`default_nettype none
// ============================================================================
// herculesae_vx_sha256_wsched : iterative SHA-256 message schedule, streams
//                               W[0..ROUNDS-1] over a valid/ready port
// Rev 1.0
// ============================================================================
module herculesae_vx_sha256_wsched
  import herculesae_sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_MAX_ROUNDS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_valid_i,
  output logic         load_ready_o,
  input  logic [511:0] load_data_i,
  input  logic         flush_i,
  output logic         w_valid_o,
  input  logic         w_ready_i,
  output logic [31:0]  w_data_o,
  output logic [5:0]   w_idx_o,
  output logic         w_last_o,
  output logic         busy_o
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  wsched_state_t state_q;
  logic [5:0]    t_q;
  logic          load_ready_q;
  logic          w_valid_q;
  logic          w_last_q;
  logic          busy_q;

  sha_word_t     win_q [16];
  sha_word_t     win_d [16];
  logic          win_en;
  sha_word_t     wnext;
  logic          load_hs;
  logic          accept;

  assign load_hs = (state_q == IDLE) & load_valid_i;
  // A beat coinciding with flush is treated as never accepted.
  assign accept  = (state_q == RUN) & w_ready_i & ~flush_i;

  herculesae_vx_sha256_wsum u_wsum (
    .w0_i  (win_q[0]),
    .w1_i  (win_q[1]),
    .w9_i  (win_q[9]),
    .w14_i (win_q[14]),
    .sum_o (wnext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      t_q          <= 6'd0;
      load_ready_q <= 1'b1;
      w_valid_q    <= 1'b0;
      w_last_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid_i) begin
            state_q      <= RUN;
            t_q          <= 6'd0;
            load_ready_q <= 1'b0;
            w_valid_q    <= 1'b1;
            w_last_q     <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        RUN: begin
          if (flush_i || (w_ready_i && w_last_q)) begin
            state_q      <= IDLE;
            t_q          <= 6'd0;
            load_ready_q <= 1'b1;
            w_valid_q    <= 1'b0;
            w_last_q     <= 1'b0;
            busy_q       <= 1'b0;
          end else if (w_ready_i) begin
            t_q      <= t_q + 6'd1;
            w_last_q <= ((t_q + 6'd1) == LAST_IDX);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    win_en = 1'b0;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    if (load_hs) begin
      win_en = 1'b1;
      for (int i = 0; i < 16; i++) win_d[i] = load_data_i[32*i +: 32];
    end else if (accept) begin
      win_en = 1'b1;
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = wnext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (win_en) begin
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign load_ready_o = load_ready_q;
  assign w_valid_o    = w_valid_q;
  assign w_data_o     = win_q[0];
  assign w_idx_o      = t_q;
  assign w_last_o     = w_last_q;
  assign busy_o       = busy_q;

  a_valid_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (w_valid_o && !w_ready_i && !flush_i) |=> w_valid_o);

  a_ready_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(load_ready_o && w_valid_o));

endmodule
`default_nettype wire
